// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix scan reader: defaults, scan states and tag width.
package matrix_pkg;

    localparam int MAX_DIM    = 128;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } scan_state_t;

    // Buffered entry layout: {data, m, n, last}
    function automatic int tag_width(input int data_w, input int addr_w);
        return data_w + 2 * addr_w + 1;
    endfunction

    localparam int TAG_W_DEF = DATA_W_DEF + 2 * ADDR_W_DEF + 1;

endpackage

// File: rtl/matrix_tag_fifo.sv
// Synchronous FIFO with a registered head; count includes the entry shown at the head.
module matrix_tag_fifo
    import matrix_pkg::*;
#(
    parameter int WIDTH = TAG_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic                         head_valid,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
    logic [CNT_W-1:0] count_nx;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rd_ptr_nx = pop ? bump(rd_ptr) : rd_ptr;
        count_nx  = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // The head mirrors mem[rd_ptr_nx]; an entry written this cycle into that slot is bypassed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            rd_ptr     <= rd_ptr_nx;
            count      <= count_nx;
            head_valid <= (count_nx != '0);
            head_data  <= (push && (wr_ptr == rd_ptr_nx)) ? push_data : mem[rd_ptr_nx];
        end
    end

endmodule

// File: rtl/matrix_scan_reader.sv
// Walks mn_matrix in row- or column-major order and re-emits entries as a tagged stream.
module matrix_scan_reader
    import matrix_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              col_major,
    input  logic [ADDR_W-1:0] m_dim,
    input  logic [ADDR_W-1:0] n_dim,
    output logic              busy,
    output logic              done,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_m_addr,
    output logic [ADDR_W-1:0] mem_n_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_m,
    output logic [ADDR_W-1:0] out_n,
    output logic              out_last
);

    localparam int TAG_W = tag_width(DATA_W, ADDR_W);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DEPTH_U = FIFO_DEPTH;

    scan_state_t state, state_nx;

    logic [ADDR_W-1:0] m_lim, n_lim, m_cnt, n_cnt;
    logic              col_r;
    logic              m_end, n_end, is_last;
    logic              start_ok, start_zero, zero_done;
    logic              credit_ok, push, pop;
    int unsigned       inflight;

    logic [ADDR_W-1:0] pipe_m    [RD_LAT];
    logic [ADDR_W-1:0] pipe_n    [RD_LAT];
    logic              pipe_last [RD_LAT];
    logic              pipe_vld  [RD_LAT];

    logic [CNT_W-1:0]  fifo_count;
    logic              head_valid;
    logic [TAG_W-1:0]  head;

    assign start_ok   = (state == IDLE) && start && (m_dim != '0) && (n_dim != '0);
    assign start_zero = (state == IDLE) && start && ((m_dim == '0) || (n_dim == '0));
    assign m_end      = (m_cnt == m_lim - ADDR_W'(1));
    assign n_end      = (n_cnt == n_lim - ADDR_W'(1));
    assign is_last    = m_end && n_end;
    assign pop        = head_valid && out_ready;

    // Buffered entries plus reads still in the tag pipe must fit in the FIFO.
    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < RD_LAT; i++) inflight += 32'(pipe_vld[i]);
        credit_ok = (32'(fifo_count) + inflight) < DEPTH_U;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        mem_read = 1'b0;
        done     = zero_done;
        case (state)
            IDLE:  if (start_ok) state_nx = SCAN;
            SCAN: begin
                mem_read = credit_ok;
                if (credit_ok && is_last) state_nx = DRAIN;
            end
            DRAIN: if (pop && out_last) begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_lim     <= '0;
            n_lim     <= '0;
            m_cnt     <= '0;
            n_cnt     <= '0;
            col_r     <= 1'b0;
            zero_done <= 1'b0;
        end else begin
            zero_done <= start_zero;
            if (start_ok) begin
                m_lim <= m_dim;
                n_lim <= n_dim;
                col_r <= col_major;
                m_cnt <= '0;
                n_cnt <= '0;
            end else if (mem_read && !is_last) begin
                if (!col_r) begin
                    if (n_end) begin
                        n_cnt <= '0;
                        m_cnt <= m_cnt + 1'b1;
                    end else begin
                        n_cnt <= n_cnt + 1'b1;
                    end
                end else begin
                    if (m_end) begin
                        m_cnt <= '0;
                        n_cnt <= n_cnt + 1'b1;
                    end else begin
                        m_cnt <= m_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign mem_m_addr = m_cnt;
    assign mem_n_addr = n_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_m[i]    <= '0;
                pipe_n[i]    <= '0;
                pipe_last[i] <= 1'b0;
                pipe_vld[i]  <= 1'b0;
            end
        end else begin
            pipe_m[0]    <= m_cnt;
            pipe_n[0]    <= n_cnt;
            pipe_last[0] <= is_last;
            pipe_vld[0]  <= mem_read;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_m[i]    <= pipe_m[i-1];
                pipe_n[i]    <= pipe_n[i-1];
                pipe_last[i] <= pipe_last[i-1];
                pipe_vld[i]  <= pipe_vld[i-1];
            end
        end
    end

    assign push = pipe_vld[RD_LAT-1];

    matrix_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  ({mem_data, pipe_m[RD_LAT-1], pipe_n[RD_LAT-1], pipe_last[RD_LAT-1]}),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head),
        .count      (fifo_count)
    );

    assign out_valid = head_valid;
    assign {out_data, out_m, out_n, out_last} = head;

endmodule

// File: tb/tb_matrix_scan_reader.sv
// Bench for matrix_scan_reader: two instances (read latency 1 and 2) share stimulus, each checked against a scan-order model.
module tb_matrix_scan_reader;

    localparam int NDUT  = 2;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] m;
        logic [7:0] n;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset, start, col_major, out_ready;
    logic [7:0]  m_dim, n_dim;
    logic        busy [NDUT], done [NDUT], mem_read [NDUT], out_valid [NDUT], out_last [NDUT];
    logic [7:0]  mem_m [NDUT], mem_n [NDUT], out_m [NDUT], out_n [NDUT];
    logic [31:0] mem_data [NDUT], out_data [NDUT];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit stall  = 1'b0;
    int start_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matrix_scan_reader #(.DATA_W(32), .ADDR_W(8), .RD_LAT(1), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset(reset), .start(start), .col_major(col_major),
        .m_dim(m_dim), .n_dim(n_dim), .busy(busy[0]), .done(done[0]),
        .mem_read(mem_read[0]), .mem_m_addr(mem_m[0]), .mem_n_addr(mem_n[0]),
        .mem_data(mem_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(out_data[0]), .out_m(out_m[0]), .out_n(out_n[0]), .out_last(out_last[0])
    );

    matrix_scan_reader #(.DATA_W(32), .ADDR_W(8), .RD_LAT(2), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset(reset), .start(start), .col_major(col_major),
        .m_dim(m_dim), .n_dim(n_dim), .busy(busy[1]), .done(done[1]),
        .mem_read(mem_read[1]), .mem_m_addr(mem_m[1]), .mem_n_addr(mem_n[1]),
        .mem_data(mem_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(out_data[1]), .out_m(out_m[1]), .out_n(out_n[1]), .out_last(out_last[1])
    );

    // Memory model: entry value 16*m+n, visible RD_LAT cycles after the read; poison otherwise.
    logic [16:0] hist [NDUT][2];

    function automatic logic [31:0] mval(input logic [16:0] h);
        return h[16] ? (32'(h[15:8]) * 32'd16 + 32'(h[7:0])) : 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            hist[k][1] <= hist[k][0];
            hist[k][0] <= {mem_read[k], mem_m[k], mem_n[k]};
        end
    end

    assign mem_data[0] = mval(hist[0][0]);
    assign mem_data[1] = mval(hist[1][1]);

    // Scan model state
    beat_t       expq [NDUT][$];
    beat_t       rdq  [NDUT][$];
    beat_t       logq [NDUT][$];
    logic [31:0] logd [NDUT][$];
    bit          active [NDUT];
    bit          zero_pend [NDUT];
    int          outstanding [NDUT];
    int          done_cnt [NDUT];
    int          done_base [NDUT];
    int          done_cyc [NDUT];
    int          first_valid [NDUT];

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    task automatic load(input int k, input int md, input int nd, input logic cm);
        beat_t b;
        for (int o = 0; o < (cm ? nd : md); o++) begin
            for (int i = 0; i < (cm ? md : nd); i++) begin
                b.m    = 8'(cm ? i : o);
                b.n    = 8'(cm ? o : i);
                b.last = (int'(b.m) == md - 1) && (int'(b.n) == nd - 1);
                expq[k].push_back(b);
                rdq[k].push_back(b);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NDUT; k++) begin
                expq[k].delete();
                rdq[k].delete();
                active[k]      = 1'b0;
                zero_pend[k]   = 1'b0;
                outstanding[k] = 0;
            end
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                beat_t b;
                bit    exp_done;
                bit    was_active;
                exp_done     = zero_pend[k];
                zero_pend[k] = 1'b0;
                was_active   = active[k];
                chk("busy", k, 64'(busy[k]), 64'(active[k]));

                if (rdq[k].size() == 0) begin
                    chk("no_read", k, 64'(mem_read[k]), 64'd0);
                end else if (mem_read[k]) begin
                    chk("credit", k, 64'(outstanding[k] < DEPTH), 64'd1);
                    b = rdq[k].pop_front();
                    chk("rd_addr", k, 64'({mem_m[k], mem_n[k]}), 64'({b.m, b.n}));
                end

                if (expq[k].size() == 0) begin
                    chk("no_valid", k, 64'(out_valid[k]), 64'd0);
                end else if (out_valid[k]) begin
                    if (first_valid[k] < 0) first_valid[k] = cyc;
                    b = expq[k][0];
                    chk("out_m", k, 64'(out_m[k]), 64'(b.m));
                    chk("out_n", k, 64'(out_n[k]), 64'(b.n));
                    chk("out_last", k, 64'(out_last[k]), 64'(b.last));
                    chk("out_data", k, 64'(out_data[k]), 64'(32'(b.m) * 32'd16 + 32'(b.n)));
                    if (out_ready) begin
                        void'(expq[k].pop_front());
                        outstanding[k]--;
                        logq[k].push_back('{m: out_m[k], n: out_n[k], last: out_last[k]});
                        logd[k].push_back(out_data[k]);
                        if (b.last) exp_done = 1'b1;
                    end
                end
                if (mem_read[k]) outstanding[k]++;

                chk("done", k, 64'(done[k]), 64'(exp_done));
                if (done[k]) begin
                    done_cnt[k]++;
                    done_cyc[k] = cyc;
                end
                if (exp_done) active[k] = 1'b0;

                if (start && !was_active) begin
                    if (m_dim == 8'd0 || n_dim == 8'd0) begin
                        zero_pend[k] = 1'b1;
                    end else begin
                        load(k, int'(m_dim), int'(n_dim), col_major);
                        active[k] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            out_ready = stall ? ((cyc % 3) == 0) : 1'b1;
        end
    endtask

    task automatic do_start(input int md, input int nd, input logic cm);
        for (int k = 0; k < NDUT; k++) begin
            logq[k].delete();
            logd[k].delete();
            done_base[k]   = done_cnt[k];
            first_valid[k] = -1;
            done_cyc[k]    = -1;
        end
        m_dim     = 8'(md);
        n_dim     = 8'(nd);
        col_major = cm;
        start     = 1'b1;
        start_cyc = cyc;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (i < budget && !(done_cnt[0] > done_base[0] && done_cnt[1] > done_base[1])) begin
            step(1);
            i++;
        end
        step(3);
        for (int k = 0; k < NDUT; k++) chk("done_count", k, 64'(done_cnt[k] - done_base[k]), 64'd1);
    endtask

    task automatic chk_reset_outputs();
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_busy", k, 64'(busy[k]), 64'd0);
            chk("rst_done", k, 64'(done[k]), 64'd0);
            chk("rst_mem_read", k, 64'(mem_read[k]), 64'd0);
            chk("rst_addr", k, 64'({mem_m[k], mem_n[k]}), 64'd0);
            chk("rst_out_valid", k, 64'(out_valid[k]), 64'd0);
            chk("rst_out_last", k, 64'(out_last[k]), 64'd0);
            chk("rst_out_data", k, 64'(out_data[k]), 64'd0);
            chk("rst_out_mn", k, 64'({out_m[k], out_n[k]}), 64'd0);
        end
    endtask

    logic [31:0] t1_data [6] = '{32'h00, 32'h01, 32'h02, 32'h10, 32'h11, 32'h12};
    logic        t1_last [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0]  t2_m    [6] = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
    logic [7:0]  t2_n    [6] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2};

    initial begin
        int base_done [NDUT];
        reset     = 1'b0;
        start     = 1'b0;
        col_major = 1'b0;
        m_dim     = '0;
        n_dim     = '0;
        out_ready = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            done_cnt[k]    = 0;
            first_valid[k] = -1;
        end
        #1;
        chk_reset_outputs();
        step(3);
        reset = 1'b1;
        step(2);

        // 2x3 row-major
        do_start(2, 3, 1'b0);
        wait_done(200);
        for (int k = 0; k < NDUT; k++) begin
            chk("t1_beats", k, 64'(logd[k].size()), 64'd6);
            chk("t1_first_valid", k, 64'(first_valid[k] - start_cyc), (k == 0) ? 64'd3 : 64'd4);
            for (int i = 0; i < 6 && i < logd[k].size(); i++) begin
                chk("t1_data", k, 64'(logd[k][i]), 64'(t1_data[i]));
                chk("t1_last", k, 64'(logq[k][i].last), 64'(t1_last[i]));
            end
        end

        // 2x3 column-major
        do_start(2, 3, 1'b1);
        wait_done(200);
        for (int k = 0; k < NDUT; k++) begin
            chk("t2_beats", k, 64'(logq[k].size()), 64'd6);
            for (int i = 0; i < 6 && i < logq[k].size(); i++)
                chk("t2_order", k, 64'({logq[k][i].m, logq[k][i].n}), 64'({t2_m[i], t2_n[i]}));
        end

        // 4x4 with out_ready high one cycle in three
        stall = 1'b1;
        do_start(4, 4, 1'b0);
        wait_done(500);
        stall = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            chk("t3_beats", k, 64'(logd[k].size()), 64'd16);
            if (logd[k].size() == 16) chk("t3_last_data", k, 64'(logd[k][15]), 64'h33);
        end

        // Zero dimension
        do_start(0, 5, 1'b0);
        wait_done(20);
        for (int k = 0; k < NDUT; k++) begin
            chk("t4_done_delay", k, 64'(done_cyc[k] - start_cyc), 64'd1);
            chk("t4_beats", k, 64'(logd[k].size()), 64'd0);
        end

        // Reset mid-scan, then a fresh 2x2
        do_start(3, 3, 1'b0);
        for (int i = 0; i < 100 && logd[0].size() < 4; i++) step(1);
        chk("t5_pre_beats", 0, 64'(logd[0].size()), 64'd4);
        reset = 1'b0;
        #1;
        chk_reset_outputs();
        for (int k = 0; k < NDUT; k++) base_done[k] = done_cnt[k];
        step(3);
        reset = 1'b1;
        step(2);
        for (int k = 0; k < NDUT; k++) chk("t5_no_done", k, 64'(done_cnt[k] - base_done[k]), 64'd0);
        do_start(2, 2, 1'b0);
        wait_done(100);
        for (int k = 0; k < NDUT; k++) chk("t5_beats", k, 64'(logd[k].size()), 64'd4);

        // 128x128 with an ignored start mid-scan
        do_start(128, 128, 1'b0);
        step(1000);
        m_dim     = 8'd2;
        n_dim     = 8'd2;
        col_major = 1'b1;
        start     = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(20000);
        step(5);
        for (int k = 0; k < NDUT; k++) begin
            chk("t6_beats", k, 64'(logq[k].size()), 64'd16384);
            chk("t6_done_once", k, 64'(done_cnt[k] - done_base[k]), 64'd1);
            if (logq[k].size() > 0)
                chk("t6_final", k, 64'(logq[k][logq[k].size()-1]), 64'({8'd127, 8'd127, 1'b1}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_scan_reader.md
Name: matrix_scan_reader

Overview:
Downstream of the matrix build stage. Once the matrix has been written into mn_matrix, this block walks it in row-major or column-major order. It issues read/m_addr/n_addr to mn_matrix and captures data_out after a fixed read latency. Entries are re-emitted as a valid/ready stream, tagged with coordinates and a last flag, for the LU compute stage. A credit-limited FIFO absorbs backpressure so no read result is ever dropped.

Parameters:
DATA_W, 32, entry width (matches mn_matrix data_out)
ADDR_W, 8, row/column address width
RD_LAT, 1, cycles from mem_read sample to valid mem_data (>=1)
FIFO_DEPTH, 4, output buffer entries; must be >= RD_LAT+2 for full throughput

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begin scan (ignored while busy)
col_major  in  1  sampled at start; 0 = n inner loop, 1 = m inner loop
m_dim  in  ADDR_W  row count, sampled at start (0..128)
n_dim  in  ADDR_W  column count, sampled at start (0..128)
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse when scan completes
mem_read  out  1  read strobe to mn_matrix
mem_m_addr  out  ADDR_W  row address to mn_matrix
mem_n_addr  out  ADDR_W  column address to mn_matrix
mem_data  in  DATA_W  mn_matrix data_out
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_data  out  DATA_W  entry value
out_m  out  ADDR_W  entry row
out_n  out  ADDR_W  entry column
out_last  out  1  high on final entry of the scan

Behaviour:
- Reset (reset=0, async): state IDLE; busy, done, mem_read, out_valid, out_last = 0; addresses, out_data, out_m, out_n = 0; FIFO and in-flight pipe flushed.
- States: IDLE, SCAN, DRAIN.
- IDLE -> SCAN on start when both dims are nonzero. Dims and col_major are latched; counters are set to (0,0).
- If either dim is 0: no reads are issued, busy stays 0, and done pulses in the cycle after start.
- SCAN: mem_read=1 in a cycle only when fifo_count + inflight < FIFO_DEPTH; otherwise the address is held and mem_read=0.
- Row-major order: n increments; on n = n_dim-1, n wraps to 0 and m increments. Column-major swaps the roles of m and n.
- SCAN -> DRAIN in the cycle after the read of element (m_dim-1, n_dim-1) is issued.
- Tag pipe: RD_LAT-deep shift register carrying {m, n, last, vld} alongside each read. mem_data is pushed into the FIFO with its tag at the end of cycle T+RD_LAT, where T is the mem_read cycle.
- FIFO output is registered. out_valid is asserted the cycle after the push (T+RD_LAT+1).
- Stream is AXI-style: a transfer occurs when out_valid && out_ready. While out_valid && !out_ready, out_data, out_m, out_n and out_last are held stable.
- Simultaneous push and pop on a full FIFO is legal. The credit rule means a push can never hit a full FIFO without a same-cycle pop.
- DRAIN -> IDLE when the out_last transfer completes. done pulses in that same cycle; busy drops in the next cycle.
- Latency with out_ready=1: start sampled at edge 0, first mem_read in cycle 1, first out_valid in cycle 2+RD_LAT. Throughput is then 1 entry/cycle.
- start while busy: ignored, with no effect on counters.
- Reset mid-scan: immediate return to IDLE; buffered data discarded; done is not pulsed.
- Max dims 128x128 = 16384 entries. The element counter is 15 bits; the last-flag compare uses the latched dims.

Decomposition:
- Shared package matrix_pkg: MAX_DIM=128, DATA_W/ADDR_W defaults, scan state encoding (IDLE/SCAN/DRAIN), tag struct width constant.
- One sub-module: matrix_tag_fifo, a synchronous FIFO of width DATA_W+2*ADDR_W+1 and depth FIFO_DEPTH. It exposes count, push, pop and a registered head.
- Address counters, credit logic and tag pipe live in the top module.

Test Plan:
- m=2, n=3, row-major, out_ready=1, RD_LAT=1, memory value = 16*m+n. Required: 6 beats, order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); data 0x00,01,02,10,11,12; out_last only on (1,2); first out_valid in cycle 3; done with last beat.
- Same matrix, col_major=1. Required order (0,0),(1,0),(0,1),(1,1),(0,2),(1,2).
- 4x4, out_ready toggled 1-of-3 cycles, RD_LAT=2, FIFO_DEPTH=4. Required: all 16 values in order, none dropped or duplicated, outputs stable while stalled, mem_read never issued with 4 entries outstanding.
- m_dim=0, n_dim=5, start. Required: no mem_read, no out_valid, busy=0, done pulse exactly 1 cycle after start.
- 3x3 scan with reset driven low after 4 beats, then released, then a new 2x2 start. Required: outputs 0 immediately on reset, no done; new scan emits exactly 4 correct beats.
- 128x128 row-major, out_ready=1. Required: 16384 beats, out_last on (127,127), done once, and a second start pulse mid-scan has no effect.
